// File: rtl/ser_sched_pkg.sv
// Shared definitions for the serializer transmit scheduler.
// Holds the scheduler state enum, default word width / idle fill pattern,
// and a small width helper used for counters and grant indices.
package ser_sched_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned NumReqDef   = 4;
  localparam int unsigned WordWDef    = 16;
  localparam logic [15:0] IdleWordDef = 16'hBC50;

  // Bits needed to index n items; never returns zero so vectors stay legal.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_tx_scheduler_if.sv
// Requester-side handshake bundle for ser_tx_scheduler.
//   in_valid : per-requester word valid (requester -> scheduler)
//   in_data  : per-requester word, slice i belongs to requester i
//   in_ready : one-hot accept strobe (scheduler -> requester)
// master = requester side, slave = scheduler side.
interface ser_tx_scheduler_if
  import ser_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned WORD_W  = WordWDef
);

  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ*WORD_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches the request vector starting one past the
// previous grant (wrapping) and returns the first set request.
//   req_i         : request vector
//   last_grant_i  : index of the previous winner
//   grant_o       : one-hot grant (zero when no request)
//   grant_idx_o   : index of the winner
//   grant_valid_o : at least one request was set
module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned IdxW    = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    grant_idx_o,
  output logic               grant_valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    // Offset 1..NUM_REQ so the previous winner is checked last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_grant_i) + k) % NUM_REQ);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
    if (grant_valid_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Serializer transmit scheduler. Picks one requester word per WORD_W-cycle
// slot (round robin), hands it to the serializer as a registered parallel
// word with a one-cycle load pulse, and optionally fills empty slots with an
// idle pattern.
//   clk, reset  : clock, asynchronous active-high reset
//   en          : enable; only gates new slots, never aborts a word in flight
//   req         : requester handshake bundle (slave side)
//   ser_pdata   : registered parallel word
//   ser_load    : registered load pulse, high in the cnt=0 cycle of a word
//   busy        : a word is being shifted
//   words_sent  : requester words loaded (wraps)
module ser_tx_scheduler
  import ser_sched_pkg::*;
#(
  parameter int unsigned       NUM_REQ   = NumReqDef,
  parameter int unsigned       WORD_W    = WordWDef,
  parameter bit                IDLE_EN   = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_WORD = IdleWordDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  ser_tx_scheduler_if.slave req,
  output logic [WORD_W-1:0] ser_pdata,
  output logic              ser_load,
  output logic              busy,
  output logic [15:0]       words_sent
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  localparam int unsigned CntW = idx_w(WORD_W);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  logic [WORD_W-1:0] pdata_q, pdata_d;
  logic              load_q, load_d;
  logic [15:0]       sent_q, sent_d;

  logic               slot_open;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IdxW-1:0]    win_idx;
  logic               win_valid;
  logic [WORD_W-1:0]  word_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign word_arr[g] = req.in_data[g*WORD_W +: WORD_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_arb (
    .req_i         (req.in_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (win_onehot),
    .grant_idx_o   (win_idx),
    .grant_valid_o (win_valid)
  );

  // A slot opens when idle, or in the last bit of the current word so the
  // next word loads with no gap.
  always_comb begin
    slot_open    = en && ((state_q == StIdle) || (cnt_q == CntLast));
    req.in_ready = (slot_open && win_valid && !reset) ? win_onehot : '0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    pdata_d      = pdata_q;
    load_d       = 1'b0;
    sent_d       = sent_q;

    if (state_q == StBusy) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (slot_open) begin
      if (win_valid) begin
        pdata_d      = word_arr[win_idx];
        load_d       = 1'b1;
        cnt_d        = '0;
        state_d      = StBusy;
        last_grant_d = win_idx;
        sent_d       = sent_q + 16'd1;
      end else if (IDLE_EN) begin
        pdata_d = IDLE_WORD;
        load_d  = 1'b1;
        cnt_d   = '0;
        state_d = StBusy;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if ((state_q == StBusy) && (cnt_q == CntLast)) begin
      // Word finished while disabled: park in idle.
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      pdata_q      <= '0;
      load_q       <= 1'b0;
      sent_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      pdata_q      <= pdata_d;
      load_q       <= load_d;
      sent_q       <= sent_d;
    end
  end

  assign ser_pdata  = pdata_q;
  assign ser_load   = load_q;
  assign busy       = (state_q == StBusy);
  assign words_sent = sent_q;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Bench for ser_tx_scheduler: two instances (idle fill on / off) driven by
// per-requester word queues, checked every cycle against a slot-level model.
module tb_ser_tx_scheduler;

  localparam int NR = 4;
  localparam int WW = 16;

  logic clk;
  logic reset;
  logic en;

  logic [WW-1:0] pd  [2];
  logic          ld  [2];
  logic          by  [2];
  logic [15:0]   ws  [2];
  logic [NR-1:0] rdy [2];

  ser_tx_scheduler_if #(.NUM_REQ(NR), .WORD_W(WW)) ifa ();
  ser_tx_scheduler_if #(.NUM_REQ(NR), .WORD_W(WW)) ifb ();

  ser_tx_scheduler #(.NUM_REQ(NR), .WORD_W(WW), .IDLE_EN(1'b1), .IDLE_WORD(16'hBC50)) dut0 (
    .clk(clk), .reset(reset), .en(en), .req(ifa),
    .ser_pdata(pd[0]), .ser_load(ld[0]), .busy(by[0]), .words_sent(ws[0])
  );

  ser_tx_scheduler #(.NUM_REQ(NR), .WORD_W(WW), .IDLE_EN(1'b0), .IDLE_WORD(16'hBC50)) dut1 (
    .clk(clk), .reset(reset), .en(en), .req(ifb),
    .ser_pdata(pd[1]), .ser_load(ld[1]), .busy(by[1]), .words_sent(ws[1])
  );

  assign rdy[0] = ifa.in_ready;
  assign rdy[1] = ifb.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Pending words per DUT per requester.
  logic [15:0] fq [2][NR][16];
  int hd [2][NR];
  int tl [2][NR];

  // Slot-level model: m_left = cycles of the current word still to shift.
  int          m_left [2];
  int          m_last [2];
  logic [15:0] m_sent [2];
  logic [15:0] m_pdata [2];
  logic        m_load [2];

  int cyc = 0;
  int n_ld = 0;
  int n_ld1 = 0;
  int ld_cyc [64];
  logic [15:0] ld_dat [64];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int winner(int d);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_last[d] + k) % NR;
      if (hd[d][i] != tl[d][i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_slot(int d);
    return en && (m_left[d] <= 1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d]  = 0;
      m_last[d]  = NR - 1;
      m_sent[d]  = 16'h0;
      m_pdata[d] = 16'h0;
      m_load[d]  = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    logic [NR-1:0]    v [2];
    logic [NR*WW-1:0] dd [2];
    for (int d = 0; d < 2; d++) begin
      v[d] = '0;
      dd[d] = '0;
      for (int r = 0; r < NR; r++) begin
        if (hd[d][r] != tl[d][r]) begin
          v[d][r] = 1'b1;
          dd[d][r*WW +: WW] = fq[d][r][hd[d][r]];
        end
      end
    end
    ifa.in_valid = v[0];
    ifa.in_data  = dd[0];
    ifb.in_valid = v[1];
    ifb.in_data  = dd[1];
  endtask

  task automatic push(int r, logic [15:0] w);
    for (int d = 0; d < 2; d++) begin
      fq[d][r][tl[d][r]] = w;
      tl[d][r]++;
    end
    drive_inputs();
  endtask

  task automatic model_step();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int w;
      if (reset) begin
        m_left[d] = 0; m_last[d] = NR - 1; m_sent[d] = 16'h0;
        m_pdata[d] = 16'h0; m_load[d] = 1'b0;
      end else begin
        w = winner(d);
        if (m_slot(d)) begin
          if (w >= 0) begin
            m_pdata[d] = fq[d][w][hd[d][w]];
            m_load[d]  = 1'b1;
            m_left[d]  = WW;
            m_last[d]  = w;
            m_sent[d]  = m_sent[d] + 16'd1;
            hd[d][w]++;
          end else if (d == 0) begin
            m_pdata[d] = 16'hBC50;
            m_load[d]  = 1'b1;
            m_left[d]  = WW;
          end else begin
            m_load[d] = 1'b0;
            m_left[d] = 0;
          end
        end else begin
          m_load[d] = 1'b0;
          if (m_left[d] > 0) m_left[d]--;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      int w;
      logic [NR-1:0] er;
      w = winner(d);
      er = (!reset && m_slot(d) && w >= 0) ? NR'(1 << w) : '0;
      check($sformatf("in_ready%0d", d), 32'(rdy[d]), 32'(er));
      check($sformatf("ser_load%0d", d), 32'(ld[d]), 32'(m_load[d]));
      check($sformatf("ser_pdata%0d", d), 32'(pd[d]), 32'(m_pdata[d]));
      check($sformatf("busy%0d", d), 32'(by[d]), 32'(m_left[d] > 0));
      check($sformatf("words_sent%0d", d), 32'(ws[d]), 32'(m_sent[d]));
    end
    if (ld[0] === 1'b1 && n_ld < 64) begin
      ld_cyc[n_ld] = cyc;
      ld_dat[n_ld] = pd[0];
      n_ld++;
    end
    if (ld[1] === 1'b1) n_ld1++;
  endtask

  function automatic logic [31:0] lget_dat(int i);
    return (i < n_ld) ? 32'(ld_dat[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lget_gap(int i);
    return (i > 0 && i < n_ld) ? 32'(ld_cyc[i] - ld_cyc[i-1]) : 32'hDEAD_BEEF;
  endfunction

  always begin
    @(posedge clk or posedge reset);
    model_step();
  end

  always begin
    @(posedge clk);
    #1;
    drive_inputs();
  end

  always begin
    @(negedge clk);
    compare_all();
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin : main
    int mark;
    int mark1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NR; r++) begin
        hd[d][r] = 0;
        tl[d][r] = 0;
      end
    model_reset();
    reset = 1'b1;
    en = 1'b0;
    drive_inputs();
    step(2);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_words_sent", 32'(ws[0]), 32'h0);
    check("rst_pdata", 32'(pd[0]), 32'h0);
    check("rst_busy", 32'(by[0]), 32'h0);

    // Single word from requester 0
    step(1);
    push(0, 16'hA5A5);
    en = 1'b1;
    @(negedge clk);
    check("a_ready0", 32'(rdy[0]), 32'h1);
    check("a_ready1", 32'(rdy[1]), 32'h1);
    step(1);
    @(negedge clk);
    check("a_load", 32'(ld[0]), 32'h1);
    check("a_pdata", 32'(pd[0]), 32'hA5A5);
    check("a_sent", 32'(ws[0]), 32'h1);

    // Two requesters together: req0 first, req2 exactly one word later
    en = 1'b0;
    step(20);
    do_reset();
    mark = n_ld;
    push(0, 16'hA5A5);
    push(2, 16'h3C3C);
    en = 1'b1;
    step(40);
    check("b_first", lget_dat(mark), 32'hA5A5);
    check("b_second", lget_dat(mark + 1), 32'h3C3C);
    check("b_gap", lget_gap(mark + 1), 32'd16);

    // All requesters continuously valid: strict rotation, 16-cycle spacing
    en = 1'b0;
    step(20);
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NR; r++)
        push(r, {4'(r), 4'(k), 8'h5A});
    mark = n_ld;
    en = 1'b1;
    step(8 * 16 + 5);
    for (int j = 0; j < 8; j++) begin
      logic [31:0] dv;
      dv = lget_dat(mark + j);
      check($sformatf("c_order%0d", j), 32'(dv[15:12]), 32'(j % NR));
      if (j > 0) check($sformatf("c_gap%0d", j), lget_gap(mark + j), 32'd16);
    end
    check("c_sent", 32'(ws[0]), 32'd8);

    // No requesters: idle fill on dut0, silence on dut1
    mark = n_ld;
    mark1 = n_ld1;
    step(40);
    check("d_idle0", lget_dat(mark), 32'hBC50);
    check("d_idle1", lget_dat(mark + 1), 32'hBC50);
    check("d_idle_gap", lget_gap(mark + 1), 32'd16);
    check("d_sent", 32'(ws[0]), 32'd8);
    check("d_noload1", 32'(n_ld1 - mark1), 32'd0);
    check("d_busy1", 32'(by[1]), 32'h0);

    // en dropped at cnt=5: word completes, then idle, then pending word loads
    en = 1'b0;
    step(20);
    push(1, 16'h1111);
    en = 1'b1;
    step(6);
    en = 1'b0;
    push(2, 16'h2222);
    mark = n_ld;
    step(10);
    @(negedge clk);
    check("e_busy_last", 32'(by[0]), 32'h1);
    step(1);
    @(negedge clk);
    check("e_idle", 32'(by[0]), 32'h0);
    check("e_noload", 32'(n_ld - mark), 32'd0);
    check("e_noready", 32'(rdy[0]), 32'h0);
    step(5);
    en = 1'b1;
    @(negedge clk);
    check("e_ready0", 32'(rdy[0]), 32'h4);
    check("e_ready1", 32'(rdy[1]), 32'h4);
    step(1);
    @(negedge clk);
    check("e_load", 32'(ld[0]), 32'h1);
    check("e_pdata", 32'(pd[0]), 32'h2222);

    // Reset at cnt=7, then req0 beats req3
    en = 1'b0;
    step(20);
    push(1, 16'h7777);
    en = 1'b1;
    step(8);
    reset = 1'b1;
    #1;
    check("f_load", 32'(ld[0]), 32'h0);
    check("f_busy", 32'(by[0]), 32'h0);
    check("f_pdata", 32'(pd[0]), 32'h0);
    check("f_sent", 32'(ws[0]), 32'h0);
    check("f_ready", 32'(rdy[0]), 32'h0);
    push(0, 16'h0A0A);
    push(3, 16'h3B3B);
    step(2);
    reset = 1'b0;
    @(negedge clk);
    check("f_ready0", 32'(rdy[0]), 32'h1);
    check("f_ready1", 32'(rdy[1]), 32'h1);
    step(1);
    @(negedge clk);
    check("f_pdata0", 32'(pd[0]), 32'h0A0A);
    check("f_sent1", 32'(ws[0]), 32'h1);
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_tx_scheduler.md
SER_TX_SCHEDULER -- requirements
Module: ser_tx_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_REQ, 4, number of requesters (2..8)
  WORD_W, 16, serializer word width in bits
  IDLE_EN, 1, insert IDLE_WORD into empty slots when 1
  IDLE_WORD, 16'hBC50, fill pattern sent when no requester is valid
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  input  1  single clock; all logic on rising edge
  reset  input  1  asynchronous, active-high reset
  en  input  1  scheduler enable; gates new slots only
  in_valid  input  NUM_REQ  per-requester word valid
  in_data  input  NUM_REQ*WORD_W  per-requester word; slice i is requester i
  in_ready  output  NUM_REQ  one-hot accept strobe; combinational
  ser_pdata  output  WORD_W  registered parallel word to serializer
  ser_load  output  1  registered one-cycle load pulse to serializer
  busy  output  1  high while a word is being shifted
  words_sent  output  16  count of requester words loaded; wraps

Function
REQ-003 States SHALL be IDLE and BUSY; bit counter cnt spans 0..WORD_W-1.
REQ-004 slot_open SHALL be high when en=1 and (state=IDLE or (state=BUSY and cnt=WORD_W-1)).
REQ-005 In a slot_open cycle, a round-robin winner SHALL be chosen among valid requesters, starting at last_grant+1 mod NUM_REQ.
REQ-006 in_ready SHALL be one-hot on the winner only in a slot_open cycle with a winner; otherwise all zero.
REQ-007 A transfer SHALL occur only when in_valid[i] and in_ready[i] are both high; requesters hold in_valid and in_data until accepted.
REQ-008 On a transfer edge: ser_pdata <= in_data[winner], ser_load <= 1, cnt <= 0, state <= BUSY, last_grant <= winner, words_sent += 1.
REQ-009 In a slot_open cycle with no valid requester and IDLE_EN=1: ser_pdata <= IDLE_WORD, ser_load <= 1, cnt <= 0, state <= BUSY; last_grant and words_sent unchanged.
REQ-010 In a slot_open cycle with no valid requester and IDLE_EN=0, or when en=0 at cnt=WORD_W-1: state <= IDLE, ser_load <= 0, ser_pdata held.
REQ-011 ser_load SHALL be high exactly one cycle (the cnt=0 cycle) per loaded word; back-to-back loads are exactly WORD_W cycles apart.
REQ-012 In BUSY, cnt SHALL increment by 1 each cycle; en=0 SHALL NOT abort the word in flight.
REQ-013 busy SHALL equal (state=BUSY).
REQ-014 words_sent SHALL wrap from 16'hFFFF to 16'h0000.
REQ-015 A requester dropping in_valid before acceptance is a protocol violation; behaviour is unspecified beyond no X on outputs.

Reset
REQ-016 reset=1 SHALL asynchronously force state=IDLE, cnt=0, ser_load=0, ser_pdata=0, last_grant=NUM_REQ-1, words_sent=0; in_ready=0 while reset is high.
REQ-017 Reset mid-word SHALL abandon the word; the first slot after release SHALL go to requester 0 if valid.

Structure
REQ-018 Package ser_sched_pkg SHALL hold the state enum and WORD_W/IDLE_WORD default constants.
REQ-019 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs req vector and last_grant; outputs one-hot grant and grant index).

Verification
REQ-020 Req0 valid with 16'hA5A5, en=1 -> in_ready[0] one cycle, next cycle ser_load=1 with ser_pdata=A5A5, words_sent=1.
REQ-021 Req0=A5A5 and req2=3C3C valid together -> A5A5 loaded first, 3C3C loaded exactly 16 cycles later.
REQ-022 All 4 requesters continuously valid -> grant order 0,1,2,3,0,1 with loads every 16 cycles.
REQ-023 No requesters, IDLE_EN=1 -> ser_load every 16 cycles with BC50, words_sent stays 0; IDLE_EN=0 -> ser_load stays 0, busy=0.
REQ-024 en dropped at cnt=5 -> current word completes, no further load, state IDLE at cnt=15+1; en re-asserted -> pending requester loaded next cycle.
REQ-025 reset asserted at cnt=7 -> outputs at reset values immediately; after release req0 and req3 valid -> req0 granted first.
